// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the instruction and data caches for a single
// next-level (L2) port, with an l2_ack timeout and saturating grant counters.
module l2_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] i_add,
    input  logic [ADDR_W-1:0] d_add,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_ack,
    output logic              d_ack,
    output logic [LINE_W-1:0] rdata,
    output logic              err,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_add,
    input  logic              l2_ack,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req with a valid address and holds both
    // until its one-cycle ack; the downstream side sees l2_req/l2_add held
    // until it answers with a single l2_ack cycle carrying l2_rdata.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        owner_d;
    logic        last_d;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic        pick_d;
    logic        timeout_hit;

    // D wins only if I is idle or I was the last one served.
    assign pick_d      = d_req && (!i_req || !last_d);
    assign timeout_hit = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = REQ;
            REQ:     if (l2_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        l2_req    = (state == REQ);
        i_gnt     = ((state == REQ) || (state == RESP)) && !owner_d;
        d_gnt     = ((state == REQ) || (state == RESP)) && owner_d;
        i_ack     = (state == RESP) && !owner_d;
        d_ack     = (state == RESP) && owner_d;
        err       = (state == RESP) && err_q;
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            last_d   <= 1'b1;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
            rdata    <= '0;
            l2_add   <= '0;
            i_grants <= 32'd0;
            d_grants <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d  <= pick_d;
                        last_d   <= pick_d;
                        l2_add   <= pick_d ? d_add : i_add;
                        wait_cnt <= 8'd0;
                    end
                end
                REQ: begin
                    // An ack in the timeout cycle still counts as a success.
                    if (l2_ack) begin
                        rdata <= l2_rdata;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (!err_q) begin
                        if (owner_d) begin
                            if (d_grants != 32'hFFFF_FFFF) d_grants <= d_grants + 32'd1;
                        end else begin
                            if (i_grants != 32'hFFFF_FFFF) i_grants <= i_grants + 32'd1;
                        end
                    end
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
